// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller for the five-stage in-order pipeline.
// Ports:
//   clk, rst (sync active-low)
//   id_valid/id_rs/id_rs_used/id_rt/id_rt_used/id_rd/id_regwrite/id_is_load/id_jump
//     describe the instruction currently in ID
//   ex_br_taken : taken branch resolved in EX
//   stall, flush_fd, flush_dx : same-cycle pipeline control
//   fwd_a, fwd_b : registered operand-forward selects for the instruction in EX
//   stall_cnt, flush_cnt : saturating performance counters
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FWD_EN     = 1,
    parameter int FWD_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rs_used,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              id_jump,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              flush_fd,
    output logic              flush_dx,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Scoreboard: bit/entry k is the producer currently in stage k (1 = EX).
    logic [DEPTH:1]    v_q, v_d;
    logic [DEPTH:1]    ld_q, ld_d;
    logic [REG_AW-1:0] rd_q [1:DEPTH];

    logic [FWD_W-1:0] fwd_a_q, fwd_a_d;
    logic [FWD_W-1:0] fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [FWD_W-1:0] code_a, code_b;
    logic             haz_a, haz_b;
    logic             issue, ins;

    // Walk from oldest to youngest so the smallest matching stage wins.
    always_comb begin
        code_a = '0;
        haz_a  = 1'b0;
        code_b = '0;
        haz_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs_used && id_rs != '0 && v_q[k] && rd_q[k] == id_rs) begin
                code_a = '0;
                haz_a  = 1'b0;
                // Write-through register file covers the oldest stage.
                if (k < DEPTH) begin
                    if (FWD_EN != 0) begin
                        code_a = FWD_W'(k);
                        haz_a  = ld_q[k] && (k < LOAD_STAGE);
                    end else begin
                        haz_a  = 1'b1;
                    end
                end
            end
            if (id_rt_used && id_rt != '0 && v_q[k] && rd_q[k] == id_rt) begin
                code_b = '0;
                haz_b  = 1'b0;
                if (k < DEPTH) begin
                    if (FWD_EN != 0) begin
                        code_b = FWD_W'(k);
                        haz_b  = ld_q[k] && (k < LOAD_STAGE);
                    end else begin
                        haz_b  = 1'b1;
                    end
                end
            end
        end
    end

    // A taken branch overrides the stall: the ID instruction is dropped.
    assign stall    = rst & id_valid & (haz_a | haz_b) & ~ex_br_taken;
    assign flush_dx = rst & ex_br_taken;
    assign flush_fd = rst & (ex_br_taken | (id_jump & id_valid & ~stall));

    assign issue = id_valid & ~stall & ~ex_br_taken;
    assign ins   = issue & id_regwrite & (id_rd != '0);

    always_comb begin
        v_d         = {v_q[DEPTH-1:1], ins};
        ld_d        = {ld_q[DEPTH-1:1], ins & id_is_load};
        fwd_a_d     = issue ? code_a : '0;
        fwd_b_d     = issue ? code_b : '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ex_br_taken && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q         <= '0;
            ld_q        <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int k = 1; k <= DEPTH; k++)
                rd_q[k] <= '0;
        end else begin
            v_q         <= v_d;
            ld_q        <= ld_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rd_q[1]     <= id_rd;
            for (int k = DEPTH; k >= 2; k--)
                rd_q[k] <= rd_q[k-1];
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit: forwarding instance plus a
// no-forwarding instance with narrow counters for saturation.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used;
    logic       id_regwrite, id_is_load, id_jump, ex_br_taken;

    logic        s1, ffd1, fdx1;
    logic [1:0]  fa1, fb1;
    logic [15:0] sc1, fc1;
    logic        s0, ffd0, fdx0;
    logic [1:0]  fa0, fb0;
    logic [1:0]  sc0, fc0;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_hazard_unit #(
        .REG_AW(5), .DEPTH(3), .LOAD_STAGE(2),
        .FWD_EN(1), .FWD_W(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_jump(id_jump),
        .ex_br_taken(ex_br_taken),
        .stall(s1), .flush_fd(ffd1), .flush_dx(fdx1),
        .fwd_a(fa1), .fwd_b(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hazard_unit #(
        .REG_AW(5), .DEPTH(3), .LOAD_STAGE(2),
        .FWD_EN(0), .FWD_W(2), .CNT_W(2)
    ) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_jump(id_jump),
        .ex_br_taken(ex_br_taken),
        .stall(s0), .flush_fd(ffd0), .flush_dx(fdx0),
        .fwd_a(fa0), .fwd_b(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    task automatic set_id(input logic v,
                          input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu,
                          input logic [4:0] rd, input logic rw,
                          input logic ld);
        id_valid    = v;
        id_rs       = rs;
        id_rs_used  = rsu;
        id_rt       = rt;
        id_rt_used  = rtu;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_jump     = 1'b0;
        ex_br_taken = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        rst = 1'b0;
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd1, 1, 1);
        id_jump = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        tests++;
        if ({s1, ffd1, fdx1} !== 3'b000) begin
            fails++;
            $display("FAIL rst_ctrl got %b exp 000", {s1, ffd1, fdx1});
        end
        exp_q.push_back(4'h0);
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL rst_fwd got %h exp %h", {fa1, fb1}, e);
        end
        tests++;
        if (sc1 !== 16'd0 || fc1 !== 16'd0 || sc0 !== 2'd0) begin
            fails++;
            $display("FAIL rst_cnt got %0d/%0d/%0d exp 0", sc1, fc1, sc0);
        end
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alu_pair();
        logic [3:0] e;
        // add r1,r2,r3
        set_id(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);
        #1;
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL alu1_stall got %b exp 0", s1);
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL alu1_fwd got %h exp %h", {fa1, fb1}, e);
        end
        // add r4,r1,r5
        set_id(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);
        #1;
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL alu2_stall got %b exp 0", s1);
        end
        exp_q.push_back({2'd1, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL alu2_fwd got %h exp %h", {fa1, fb1}, e);
        end
    endtask

    task automatic test_distance();
        logic [3:0] e;
        // r1 at distance 2, r6 unrelated; writes r0
        set_id(1, 5'd1, 1, 5'd6, 1, 5'd0, 1, 0);
        #1;
        exp_q.push_back({2'd2, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL dist2_fwd got %h exp %h", {fa1, fb1}, e);
        end
        // r1 at distance 3, r4 at distance 2; writes r0
        set_id(1, 5'd1, 1, 5'd4, 1, 5'd0, 1, 0);
        #1;
        exp_q.push_back({2'd0, 2'd2});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL dist3_fwd got %h exp %h", {fa1, fb1}, e);
        end
        // read r0 after write to r0
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
        #1;
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL r0_stall got %b exp 0", s1);
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL r0_fwd got %h exp %h", {fa1, fb1}, e);
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        adv();
        adv();
    endtask

    task automatic test_load_use();
        logic [3:0] e;
        // lw r3
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1);
        #1;
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL lw_fwd got %h exp %h", {fa1, fb1}, e);
        end
        // add r6,r3,r3
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd6, 1, 0);
        #1;
        tests++;
        if (s1 !== 1'b1) begin
            fails++;
            $display("FAIL lu_stall1 got %b exp 1", s1);
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL lu_bubble got %h exp %h", {fa1, fb1}, e);
        end
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL lu_stall2 got %b exp 0", s1);
        end
        exp_q.push_back({2'd2, 2'd2});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL lu_fwd got %h exp %h", {fa1, fb1}, e);
        end
        tests++;
        if (sc1 !== 16'd1) begin
            fails++;
            $display("FAIL lu_cnt got %0d exp 1", sc1);
        end
    endtask

    task automatic test_branch();
        logic [3:0] e;
        // lw r8
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1);
        #1;
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL br_lw_fwd got %h exp %h", {fa1, fb1}, e);
        end
        // add r9,r8,r8 with taken branch in EX
        set_id(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
        ex_br_taken = 1'b1;
        #1;
        tests++;
        if ({s1, ffd1, fdx1} !== 3'b011) begin
            fails++;
            $display("FAIL br_ctrl got %b exp 011", {s1, ffd1, fdx1});
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL br_fwd got %h exp %h", {fa1, fb1}, e);
        end
        tests++;
        if (fc1 !== 16'd1 || sc1 !== 16'd1) begin
            fails++;
            $display("FAIL br_cnt got %0d/%0d exp 1/1", fc1, sc1);
        end
        // r9 must not be in flight; r8 now at MEM
        set_id(1, 5'd9, 1, 5'd8, 1, 5'd0, 0, 0);
        #1;
        tests++;
        if ({s1, ffd1, fdx1} !== 3'b000) begin
            fails++;
            $display("FAIL br_after_ctrl got %b exp 000", {s1, ffd1, fdx1});
        end
        exp_q.push_back({2'd0, 2'd2});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL br_noins got %h exp %h", {fa1, fb1}, e);
        end
        // jump alone
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        id_jump = 1'b1;
        #1;
        tests++;
        if ({s1, ffd1, fdx1} !== 3'b010) begin
            fails++;
            $display("FAIL jump_ctrl got %b exp 010", {s1, ffd1, fdx1});
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e || fc1 !== 16'd1) begin
            fails++;
            $display("FAIL jump_fwd got %h/%0d exp %h/1", {fa1, fb1}, fc1, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [3:0] e;
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        adv();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd6, 1, 0);
        #1;
        tests++;
        if (s1 !== 1'b1) begin
            fails++;
            $display("FAIL rs_pre_stall got %b exp 1", s1);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL rs_stall got %b exp 0", s1);
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e || sc1 !== 16'd0 || fc1 !== 16'd0) begin
            fails++;
            $display("FAIL rs_state got %h/%0d/%0d exp %h/0/0",
                     {fa1, fb1}, sc1, fc1, e);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (s1 !== 1'b0) begin
            fails++;
            $display("FAIL rs_after_stall got %b exp 0", s1);
        end
        exp_q.push_back({2'd0, 2'd0});
        adv();
        e = exp_q.pop_front();
        tests++;
        if ({fa1, fb1} !== e) begin
            fails++;
            $display("FAIL rs_after_fwd got %h exp %h", {fa1, fb1}, e);
        end
    endtask

    task automatic test_nofwd();
        logic [3:0] e;
        logic       exp_st [3];
        exp_st = '{1'b1, 1'b1, 1'b0};
        // add r1,r2,r3
        set_id(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);
        #1;
        tests++;
        if (s0 !== 1'b0) begin
            fails++;
            $display("FAIL nf_prod_stall got %b exp 0", s0);
        end
        adv();
        // add r4,r1,r5 held until producer reaches WB
        set_id(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (s0 !== exp_st[i]) begin
                fails++;
                $display("FAIL nf_stall%0d got %b exp %b", i, s0, exp_st[i]);
            end
            exp_q.push_back({2'd0, 2'd0});
            adv();
            e = exp_q.pop_front();
            tests++;
            if ({fa0, fb0} !== e) begin
                fails++;
                $display("FAIL nf_fwd%0d got %h exp %h", i, {fa0, fb0}, e);
            end
        end
        tests++;
        if (sc0 !== 2'd2) begin
            fails++;
            $display("FAIL nf_cnt got %0d exp 2", sc0);
        end
    endtask

    task automatic test_saturate();
        // add r10 then a dependent read: two more stalls on a 2-bit counter
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0);
        adv();
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0);
        adv();
        adv();
        #1;
        tests++;
        if (s0 !== 1'b0) begin
            fails++;
            $display("FAIL sat_stall got %b exp 0", s0);
        end
        adv();
        tests++;
        if (sc0 !== 2'd3) begin
            fails++;
            $display("FAIL sat_cnt got %0d exp 3", sc0);
        end
    endtask

    initial begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_pair();
        test_distance();
        test_load_use();
        test_branch();
        test_reset_mid_stall();
        test_nofwd();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order CPU pipeline (IF, ID, EX, MEM, WB).
- Keeps a shift-register scoreboard of in-flight register writes behind ID.
- Drives the ID-stage stall, the FD/DX flushes and the DX-aligned operand-forward selects, replacing the current hazard-free pipeline.
- Adds saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, stages after ID that hold pending writes (1=EX … DEPTH=WB); legal range 2..7.
- LOAD_STAGE, 2, first stage whose output latch holds load data; legal range 1..DEPTH-1.
- FWD_EN, 1, 1=forwarding enabled; 0=stall on every unresolved dependency.
- FWD_W, 2, width of forward selects; must satisfy 2^FWD_W ≥ DEPTH.
- CNT_W, 16, performance counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- id_valid, in, 1, ID holds a valid instruction.
- id_rs, in, REG_AW, source A register.
- id_rs_used, in, 1, source A is read.
- id_rt, in, REG_AW, source B register.
- id_rt_used, in, 1, source B is read.
- id_rd, in, REG_AW, destination register.
- id_regwrite, in, 1, ID instruction writes rd.
- id_is_load, in, 1, ID instruction is a load.
- id_jump, in, 1, jump decoded in ID.
- ex_br_taken, in, 1, branch resolved taken in EX.
- stall, out, 1, hold PC and FD latch; insert bubble into DX (combinational).
- flush_fd, out, 1, kill FD latch contents (combinational).
- flush_dx, out, 1, kill DX latch contents (combinational).
- fwd_a, out, FWD_W, source A select for the instruction now in EX (registered).
- fwd_b, out, FWD_W, source B select (registered).
- stall_cnt, out, CNT_W, cycles with stall=1.
- flush_cnt, out, CNT_W, taken-branch flush events.

Behaviour:
- Scoreboard: DEPTH entries {valid, rd, is_load}; entry k = producer currently in stage k.
- Every clock edge with rst=1: entry[k+1] ← entry[k] for k=1..DEPTH-1; entry[DEPTH] retires.
- entry[1] ← ID instruction iff id_valid & id_regwrite & id_rd≠0 & !stall & !ex_br_taken; otherwise bubble (valid=0).
- Match for a source: src_used & src≠0 & entry[k].valid & entry[k].rd=src. Use the smallest matching k (youngest producer).
- Register file is write-through, so a match at k=DEPTH needs no action: code 0.
- FWD_EN=1, match at k<DEPTH:
  - Forward code k = producer's output latch: 1=XM, 2=MW, …
  - Hazard only if entry[k].is_load & k<LOAD_STAGE.
- FWD_EN=0: any match at k<DEPTH is a hazard.
- stall = id_valid & hazard(A or B) & !ex_br_taken.
- flush_fd = ex_br_taken | (id_jump & id_valid & !stall).
- flush_dx = ex_br_taken.
- Simultaneous branch and stall: branch wins. stall=0, the ID instruction is dropped and is not inserted.
- fwd_a/fwd_b register each edge:
  - Take the codes computed for the ID instruction.
  - Force 0 when a bubble enters EX (stall, ex_br_taken, or !id_valid).
- Counters:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with ex_br_taken=1.
  - Both saturate at all-ones and never wrap.
- Reset (rst=0 at an edge):
  - All entries invalid; fwd_a=fwd_b=0; both counters 0.
  - While rst=0, stall, flush_fd and flush_dx are forced 0.
  - Reset mid-stall clears the hazard immediately.
- Latency:
  - Stall and flush are same-cycle combinational.
  - Forward codes are valid one cycle later, aligned with DX.
  - Load-use with LOAD_STAGE=2 costs exactly 1 stall cycle.
  - FWD_EN=0 costs DEPTH-k stall cycles for a producer at stage k.

Test Plan:
- Dependent ALU pair `add r1,r2,r3; add r4,r1,r5` -> stall never asserts; fwd_a=1 in the cycle the second add is in EX; fwd_b=0.
- ALU producer then consumer at distance 2 -> fwd=2; at distance 3 -> fwd=0. A write to r0 followed by a read of r0 -> no stall, fwd=0.
- Load-use `lw r3; add r6,r3,r3` -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=2; stall_cnt=1.
- FWD_EN=0, ALU producer then consumer at distance 1 -> stall for 2 cycles, fwd=0; stall_cnt=2.
- ex_br_taken=1 while ID holds a load-use hazard -> stall=0, flush_fd=flush_dx=1, no scoreboard insert, flush_cnt=1. id_jump alone -> flush_fd=1, flush_dx=0.
- rst=0 for 1 cycle during a load-use stall -> stall=0 immediately; after reset no entries are valid, counters=0, and the formerly dependent instruction proceeds with fwd=0.
